// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants, FSM state type and pointer helper for the register-file write arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package regfile_write_arbiter_pkg;

    localparam int RF_AW    = 3;
    localparam int RF_DW    = 8;
    localparam int RF_DEPTH = 8;

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    // Round-robin successor of a requester index, wrapping at n.
    function automatic logic [2:0] rr_next(input logic [2:0] idx, input int n);
        if (int'(idx) + 1 >= n) begin
            return 3'd0;
        end
        return idx + 3'd1;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping around.
// Latency: purely combinational.
// Backpressure: none; the caller gates req with its own eligibility.
import regfile_write_arbiter_pkg::*;

module rf_rr_pick #(
    parameter int N = 3
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   ptr,
    output logic [N-1:0] gnt,
    output logic [2:0]   idx,
    output logic         any
);

    // Search the upper segment [ptr, N) first, then wrap to [0, ptr).
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any && req[i] && (3'(i) >= ptr)) begin
                any = 1'b1;
                idx = 3'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!any && req[i]) begin
                any = 1'b1;
                idx = 3'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            gnt[i] = any && (idx == 3'(i));
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NREQ requesters (ARB_LOCK_EN adds grant locking).
// Latency: accept at edge N drives rf_we/addr/data after edge N; the register file commits at edge N+1 after that.
// Backpressure: req_ready is one-hot or zero; a requester holds valid/addr/data until it sees ready.
import regfile_write_arbiter_pkg::*;

module regfile_write_arbiter #(
    parameter int NREQ         = 3,
    parameter int AW           = RF_AW,
    parameter int DW           = RF_DW,
    parameter int LOCK_TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_lock,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_write_addr,
    output logic [DW-1:0]        rf_write_data,
    output logic [2:0]           grant_id
);

    logic [2:0]      rr_ptr;
    logic [NREQ-1:0] pick_req;
    logic [NREQ-1:0] pick_gnt;
    logic [2:0]      pick_idx;
    logic            pick_any;
    logic            eff_locked;
    logic            ptr_adv;
    logic [NREQ-1:0] owner_mask;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_data;

    // Only eligible requesters compete; nothing is eligible while reset is held.
    assign pick_req  = rst_n ? (eff_locked ? (req_valid & owner_mask) : req_valid) : '0;
    assign req_ready = pick_gnt;

    rf_rr_pick #(
        .N   (NREQ)
    ) u_pick (
        .req (pick_req),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

`ifdef ARB_LOCK_EN
    localparam int CW = $clog2(LOCK_TIMEOUT + 1);

    arb_state_t    state, state_nxt;
    logic [2:0]    lock_owner, lock_owner_nxt;
    logic [CW-1:0] lock_cnt, lock_cnt_nxt;
    logic          owner_vld;
    logic          timeout_now;
    logic          win_lock;

    // Decode the lock owner index into a requester mask.
    always_comb begin
        owner_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            owner_mask[i] = (lock_owner == 3'(i));
        end
    end

    assign owner_vld   = |(req_valid & owner_mask);
    assign win_lock    = |(pick_gnt & req_lock);
    // The timeout releases the lock in the same cycle, so others can be granted immediately.
    assign timeout_now = (state == ST_LOCKED) && !owner_vld && (lock_cnt == CW'(LOCK_TIMEOUT - 1));
    assign eff_locked  = (state == ST_LOCKED) && !timeout_now;
    // Pointer is frozen while locked, except when the owner releases with a lock=0 beat.
    assign ptr_adv     = pick_any && (!eff_locked || !win_lock);

    // Lock FSM state, owner and idle counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_ARB;
            lock_owner <= '0;
            lock_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            lock_owner <= lock_owner_nxt;
            lock_cnt   <= lock_cnt_nxt;
        end
    end

    // Next-state: enter on a locked beat, leave on an unlocked owner beat or on timeout.
    always_comb begin
        state_nxt      = state;
        lock_owner_nxt = lock_owner;
        lock_cnt_nxt   = lock_cnt;
        if (eff_locked) begin
            if (pick_any) begin
                lock_cnt_nxt = '0;
                if (!win_lock) begin
                    state_nxt = ST_ARB;
                end
            end else begin
                lock_cnt_nxt = lock_cnt + CW'(1);
            end
        end else begin
            state_nxt    = ST_ARB;
            lock_cnt_nxt = '0;
            if (pick_any && win_lock) begin
                state_nxt      = ST_LOCKED;
                lock_owner_nxt = pick_idx;
            end
        end
    end
`else
    logic unused_cfg;

    assign owner_mask = '1;
    assign eff_locked = 1'b0;
    assign ptr_adv    = pick_any;
    assign unused_cfg = (^req_lock) ^ (LOCK_TIMEOUT == 0);
`endif

    // Select the winner's address and data.
    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) begin
                win_addr = req_addr[i*AW +: AW];
                win_data = req_data[i*DW +: DW];
            end
        end
    end

    // Output registers and round-robin pointer; addr/data/id hold when nothing is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we         <= 1'b0;
            rf_write_addr <= '0;
            rf_write_data <= '0;
            grant_id      <= '0;
            rr_ptr        <= '0;
        end else begin
            rf_we <= pick_any;
            if (pick_any) begin
                rf_write_addr <= win_addr;
                rf_write_data <= win_data;
                grant_id      <= pick_idx;
            end
            if (ptr_adv) begin
                rr_ptr <= rr_next(pick_idx, NREQ);
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [2:0]  req_lock;
    logic [8:0]  req_addr;
    logic [23:0] req_data;
    logic [2:0]  req_ready;
    logic        rf_we;
    logic [2:0]  rf_write_addr;
    logic [7:0]  rf_write_data;
    logic [2:0]  grant_id;

    typedef struct packed {
        logic [2:0] a;
        logic [7:0] d;
        logic [2:0] id;
    } wb_t;

    wb_t        sb[$];
    wb_t        last;
    logic [7:0] rf_mem [8];
    int         total = 0;
    int         bad   = 0;

    regfile_write_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_lock      (req_lock),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .rf_we         (rf_we),
        .rf_write_addr (rf_write_addr),
        .rf_write_data (rf_write_data),
        .grant_id      (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file stand-in fed by the arbiter outputs.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) rf_mem[i] <= 8'h00;
        end else if (rf_we === 1'b1) begin
            rf_mem[rf_write_addr] <= rf_write_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [2:0] a, input logic [7:0] d);
        req_valid[i]      = v;
        req_addr[i*3 +: 3] = a;
        req_data[i*8 +: 8] = d;
    endtask

    // One cycle: check ready against the hand-derived vector, push the accepted beat,
    // then after the edge pop and compare the write port.
    task automatic tick(input string tag, input logic [2:0] exp_rdy);
        wb_t  e;
        logic acc;
        logic was_rst;
        #1;
        chk({tag, ".rdy"}, {29'd0, req_ready}, {29'd0, exp_rdy});
        acc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (exp_rdy[i] && req_valid[i]) begin
                acc = 1'b1;
                e.a  = req_addr[i*3 +: 3];
                e.d  = req_data[i*8 +: 8];
                e.id = 3'(i);
                sb.push_back(e);
            end
        end
        was_rst = !rst_n;
        @(posedge clk);
        #1;
        if (was_rst) begin
            sb.delete();
            last = '0;
            chk({tag, ".we"}, {31'd0, rf_we}, 32'd0);
        end else if (acc && sb.size() > 0) begin
            last = sb.pop_front();
            chk({tag, ".we"}, {31'd0, rf_we}, 32'd1);
        end else begin
            chk({tag, ".we"}, {31'd0, rf_we}, 32'd0);
        end
        chk({tag, ".addr"}, {29'd0, rf_write_addr}, {29'd0, last.a});
        chk({tag, ".data"}, {24'd0, rf_write_data}, {24'd0, last.d});
        chk({tag, ".id"},   {29'd0, grant_id},      {29'd0, last.id});
    endtask

    initial begin
        last      = '0;
        rst_n     = 1'b0;
        req_lock  = 3'b000;
        req_valid = 3'b000;
        req_addr  = '0;
        req_data  = '0;
        for (int i = 0; i < 3; i++) set_req(i, 1'b1, 3'(i + 4), 8'(8'hC0 + i));
        @(negedge clk);

        // Reset held with all requesters valid.
        tick("rst0", 3'b000);
        tick("rst1", 3'b000);

        // Single write from requester 0; pointer moves to 1.
        rst_n = 1'b1;
        req_valid = 3'b000;
        set_req(0, 1'b1, 3'd0, 8'h55);
        tick("w0", 3'b001);
        req_valid = 3'b000;
        tick("w0_idle", 3'b000);
        chk("rf0", {24'd0, rf_mem[0]}, 32'h55);

        // Steer pointer to 0 via requester 2, then all three valid for six cycles.
        set_req(2, 1'b1, 3'd2, 8'h12);
        tick("p2", 3'b100);
        set_req(0, 1'b1, 3'd3, 8'h10);
        set_req(1, 1'b1, 3'd4, 8'h11);
        set_req(2, 1'b1, 3'd5, 8'h12);
        tick("rr0", 3'b001);
        tick("rr1", 3'b010);
        tick("rr2", 3'b100);
        tick("rr3", 3'b001);
        tick("rr4", 3'b010);
        tick("rr5", 3'b100);

        // Pointer to 1, then two requesters target the same address.
        req_valid = 3'b000;
        set_req(0, 1'b1, 3'd6, 8'h66);
        tick("p1", 3'b001);
        req_valid = 3'b000;
        set_req(1, 1'b1, 3'd1, 8'hAA);
        set_req(2, 1'b1, 3'd1, 8'h33);
        tick("same1", 3'b010);
        req_valid[1] = 1'b0;
        tick("same2", 3'b100);
        chk("rf1_mid", {24'd0, rf_mem[1]}, 32'hAA);
        req_valid = 3'b000;
        tick("same_idle", 3'b000);
        chk("rf1_end", {24'd0, rf_mem[1]}, 32'h33);

        // Pointer to 2, then reset while requester 0 is valid.
        set_req(1, 1'b1, 3'd7, 8'h77);
        tick("p2b", 3'b010);
        req_valid = 3'b000;
        set_req(0, 1'b1, 3'd2, 8'h99);
        rst_n = 1'b0;
        tick("rst_acc", 3'b000);
        rst_n = 1'b1;
        set_req(0, 1'b1, 3'd2, 8'h21);
        set_req(1, 1'b1, 3'd3, 8'h22);
        set_req(2, 1'b1, 3'd4, 8'h23);
        tick("post_rst", 3'b001);
        req_valid = 3'b000;
        tick("post_idle", 3'b000);

        // Drop valid before ready on a losing requester: nothing written for it.
        set_req(1, 1'b1, 3'd5, 8'h44);
        set_req(2, 1'b1, 3'd6, 8'h45);
        tick("drop_a", 3'b010);
        req_valid = 3'b000;
        tick("drop_b", 3'b000);

`ifdef ARB_LOCK_EN
        // Pointer is 2; grant requester 2 to bring it to 0.
        set_req(2, 1'b1, 3'd7, 8'h01);
        tick("lp0", 3'b100);
        req_valid = 3'b000;
        req_lock  = 3'b001;
        set_req(0, 1'b1, 3'd0, 8'hE0);
        set_req(1, 1'b1, 3'd1, 8'hE1);
        tick("lk_b1", 3'b001);
        set_req(0, 1'b1, 3'd0, 8'hE2);
        tick("lk_b2", 3'b001);
        set_req(0, 1'b1, 3'd0, 8'hE3);
        tick("lk_b3", 3'b001);
        req_valid[0] = 1'b0;
        for (int k = 1; k <= 7; k++) tick($sformatf("lk_idle%0d", k), 3'b000);
        tick("lk_idle8", 3'b010);
        req_valid = 3'b000;
        req_lock  = 3'b000;
        tick("lk_end", 3'b000);
`else
        // Lock request ignored: requester 0 locks, yet requester 1 is granted next.
        set_req(2, 1'b1, 3'd7, 8'h01);
        tick("lp0", 3'b100);
        req_valid = 3'b000;
        req_lock  = 3'b001;
        set_req(0, 1'b1, 3'd0, 8'hE0);
        set_req(1, 1'b1, 3'd1, 8'hE1);
        tick("nolk_b1", 3'b001);
        set_req(0, 1'b1, 3'd0, 8'hE2);
        tick("nolk_b2", 3'b010);
        req_valid[1] = 1'b0;
        tick("nolk_b3", 3'b001);
        req_valid = 3'b000;
        req_lock  = 3'b000;
        tick("nolk_end", 3'b000);
`endif

        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
